// File: rtl/rv_dmem_master_if.sv
// Data-memory bus between rv_dmem_master and its memory slave.
// The request fields are held by the master until the slave acks.
interface rv_dmem_master_if;
  logic [31:0] addr;
  logic [31:0] data_s;
  logic [3:0]  data_select;
  logic        load;
  logic        store;
  logic        ack;
  logic [31:0] data_l;

  modport master (
    output addr, data_s, data_select, load, store,
    input  ack, data_l
  );

  modport slave (
    input  addr, data_s, data_select, load, store,
    output ack, data_l
  );
endinterface

// File: rtl/rv_dmem_master.sv
// Data-memory bus master: one bus request per load/store, byte enables, lane-replicated store data.
// Defining URV_MISALIGN_TRAP_EN traps misaligned H/W accesses and adds the dm_misaligned_o port.
module rv_dmem_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    x_valid_i,
  input  logic                    x_load_i,
  input  logic                    x_store_i,
  input  logic [2:0]              x_fun_i,
  input  logic [31:0]             x_dm_addr_i,
  input  logic [31:0]             x_dm_data_s_i,
  input  logic                    w_stall_i,
  input  logic                    w_stall_req_i,
  rv_dmem_master_if.master        dm,
  output logic [31:0]             dm_data_l_o,
  output logic                    dm_load_done_o,
  output logic                    dm_store_done_o,
  output logic                    dm_bus_err_o
`ifdef URV_MISALIGN_TRAP_EN
  ,
  output logic                    dm_misaligned_o
`endif
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        req_ld_q, req_ld_d;
  logic        req_st_q, req_st_d;
  logic        done_ld_q, done_ld_d;
  logic        done_st_q, done_st_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;
  logic        flush_q, flush_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [3:0]  sel_new;
  logic [31:0] wdata_new;
  logic        misaligned;
  logic        is_mem;
  logic        advance;
  logic        timeout_hit;

  // x_fun_i[2] only selects sign extension, which happens downstream.
  logic unused_fun;
  assign unused_fun = x_fun_i[2];

  assign is_mem      = x_load_i | x_store_i;
  assign advance     = ~w_stall_i & ~w_stall_req_i;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    sel_new   = 4'hf;
    wdata_new = x_dm_data_s_i;
    unique case (x_fun_i[1:0])
      2'b00: begin
        sel_new   = 4'b0001 << x_dm_addr_i[1:0];
        wdata_new = {4{x_dm_data_s_i[7:0]}};
      end
      2'b01: begin
        sel_new   = x_dm_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{x_dm_data_s_i[15:0]}};
      end
      default: begin
        sel_new   = 4'hf;
        wdata_new = x_dm_data_s_i;
      end
    endcase
  end

`ifdef URV_MISALIGN_TRAP_EN
  assign misaligned = ((x_fun_i[1:0] == 2'b01) && x_dm_addr_i[0]) ||
                      (x_fun_i[1] && (x_dm_addr_i[1:0] != 2'b00));
  assign dm_misaligned_o = mis_q;
`else
  assign misaligned = 1'b0;
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    sel_d     = sel_q;
    req_ld_d  = req_ld_q;
    req_st_d  = req_st_q;
    done_ld_d = done_ld_q;
    done_st_d = done_st_q;
    err_d     = err_q;
    mis_d     = mis_q;
    flush_d   = flush_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (x_valid_i && is_mem) begin
          if (misaligned) begin
            state_d   = StDone;
            done_ld_d = x_load_i;
            done_st_d = ~x_load_i;
            rdata_d   = '0;
            mis_d     = 1'b1;
          end else begin
            // Load wins when both load and store are flagged.
            state_d  = StBusy;
            addr_d   = {x_dm_addr_i[31:2], 2'b00};
            wdata_d  = wdata_new;
            sel_d    = sel_new;
            req_ld_d = x_load_i;
            req_st_d = ~x_load_i;
            flush_d  = 1'b0;
            cnt_d    = '0;
          end
        end
      end
      StBusy: begin
        if (!x_valid_i) flush_d = 1'b1;
        // An ack in the final counted cycle still completes normally.
        if (dm.ack || timeout_hit) begin
          req_ld_d = 1'b0;
          req_st_d = 1'b0;
          if (flush_q || !x_valid_i) begin
            state_d = StIdle;
          end else begin
            state_d   = StDone;
            done_ld_d = req_ld_q;
            done_st_d = req_st_q;
            err_d     = ~dm.ack;
            rdata_d   = (dm.ack && req_ld_q) ? dm.data_l : '0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (!x_valid_i || advance) begin
          state_d   = StIdle;
          done_ld_d = 1'b0;
          done_st_d = 1'b0;
          err_d     = 1'b0;
          mis_d     = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      sel_q     <= '0;
      req_ld_q  <= 1'b0;
      req_st_q  <= 1'b0;
      done_ld_q <= 1'b0;
      done_st_q <= 1'b0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
      flush_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      sel_q     <= sel_d;
      req_ld_q  <= req_ld_d;
      req_st_q  <= req_st_d;
      done_ld_q <= done_ld_d;
      done_st_q <= done_st_d;
      err_q     <= err_d;
      mis_q     <= mis_d;
      flush_q   <= flush_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dm.addr         = addr_q;
  assign dm.data_s       = wdata_q;
  assign dm.data_select  = sel_q;
  assign dm.load         = req_ld_q;
  assign dm.store        = req_st_q;
  assign dm_data_l_o     = rdata_q;
  assign dm_load_done_o  = done_ld_q;
  assign dm_store_done_o = done_st_q;
  assign dm_bus_err_o    = err_q;

endmodule
